// File: rtl/bitplane_to_vector_if.sv
// ============================================================================
// Module      : bitplane_to_vector_if
// Description : Row-in / vector-out handshake bundle for bitplane_to_vector.
//               The slave modport is the block's view; the master modport is the
//               row source and vector sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bitplane_to_vector_if #(
  parameter int ROWS = 8,
  parameter int COLS = 16
);
  logic [COLS-1:0]      row_in;
  logic                 row_valid;
  logic                 row_ready;
  logic                 row_last;
  logic [ROWS*COLS-1:0] vec_out;
  logic                 vec_valid;
  logic                 vec_ready;

  modport master (
    output row_in, row_valid, row_last, vec_ready,
    input  row_ready, vec_out, vec_valid
  );

  modport slave (
    input  row_in, row_valid, row_last, vec_ready,
    output row_ready, vec_out, vec_valid
  );
endinterface

`default_nettype wire

// File: rtl/bitplane_to_vector.sv
// ============================================================================
// Module      : bitplane_to_vector
// Description : Collects ROWS bit-plane rows of COLS bits and rebuilds COLS
//               byte lanes of ROWS bits each. Row r bit i lands at
//               vec_out[i*ROWS + ROWS-1-r]. A one-frame output buffer lets the
//               next frame fill while the current vector waits for its sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitplane_to_vector #(
  parameter int ROWS = 8,
  parameter int COLS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitplane_to_vector_if.slave  bus,
  input  logic                 err_clr_i,
  output logic                 frame_err_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int              CW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int              VW       = ROWS * COLS;
  localparam logic [CW-1:0]   LAST_ROW = CW'(ROWS - 1);

  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  out_state_e       out_state_q;
  logic [CW-1:0]    row_cnt_q,   row_cnt_d;
  logic [VW-1:0]    asm_q,       asm_d;
  logic [VW-1:0]    vec_q;
  logic             frame_err_q, frame_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic [VW-1:0]    row_spread;
  logic [VW-1:0]    row_mask;
  logic [VW-1:0]    merged;
  logic             row_ready;
  logic             accept;
  logic             is_last_row;
  logic             frame_done;
  logic             framing_err;

  // Only the final row of a frame can stall, and only while the buffer is
  // occupied and the sink is not taking it this cycle.
  assign is_last_row   = (row_cnt_q == LAST_ROW);
  assign row_ready     = !is_last_row || (out_state_q == OUT_EMPTY) || bus.vec_ready;
  assign accept        = bus.row_valid && row_ready;
  assign frame_done    = accept && is_last_row;
  assign framing_err   = accept && (bus.row_last != is_last_row);

  assign bus.row_ready = row_ready;
  assign bus.vec_out   = vec_q;
  assign bus.vec_valid = (out_state_q == OUT_FULL);
  assign frame_err_o   = frame_err_q;
  assign frame_cnt_o   = frame_cnt_q;

  // Scatter the incoming row onto its bit position within every lane.
  always_comb begin
    row_spread = '0;
    row_mask   = '0;
    for (int i = 0; i < COLS; i++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_cnt_q == CW'(r)) begin
          row_spread[i*ROWS + ROWS - 1 - r] = bus.row_in[i];
          row_mask[i*ROWS + ROWS - 1 - r]   = 1'b1;
        end
      end
    end
    merged = (asm_q & ~row_mask) | row_spread;
  end

  // Next-state for row counter, assembly buffer, error flag and frame count.
  always_comb begin
    row_cnt_d   = row_cnt_q;
    asm_d       = asm_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      // An early row_last abandons the partial frame; stale buffer bits are
      // overwritten row by row by the next frame, so no clear is needed.
      if (is_last_row || bus.row_last) begin
        row_cnt_d = '0;
      end else begin
        row_cnt_d = row_cnt_q + CW'(1);
      end
      if (!is_last_row) begin
        asm_d = merged;
      end
    end
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (err_clr_i) begin
      frame_err_d = 1'b0;
    end
    // A fresh error on the same edge as a clear must remain visible.
    if (framing_err) begin
      frame_err_d = 1'b1;
    end
  end

  // Fill-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt_q   <= '0;
      asm_q       <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      asm_q       <= asm_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Output buffer FSM: a completed frame always loads; a handshake without a
  // new frame empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= OUT_EMPTY;
      vec_q       <= '0;
    end else begin
      case (out_state_q)
        OUT_EMPTY: begin
          if (frame_done) begin
            out_state_q <= OUT_FULL;
            vec_q       <= merged;
          end
        end
        OUT_FULL: begin
          if (frame_done) begin
            out_state_q <= OUT_FULL;
            vec_q       <= merged;
          end else if (bus.vec_ready) begin
            out_state_q <= OUT_EMPTY;
          end
        end
        default: begin
          out_state_q <= OUT_EMPTY;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitplane_to_vector.sv
// ============================================================================
// Module      : tb_bitplane_to_vector
// Description : Directed self-checking bench for bitplane_to_vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bitplane_to_vector;

  localparam int ROWS = 8;
  localparam int COLS = 16;
  localparam int VW   = ROWS * COLS;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int          errors;
  int          checks;
  logic [15:0] exp_cnt;

  bitplane_to_vector_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  bitplane_to_vector #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .err_clr_i   (err_clr),
    .frame_err_o (frame_err),
    .frame_cnt_o (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r of the bit-plane view of V: bit i = V[i*ROWS + ROWS-1-r].
  function automatic logic [COLS-1:0] plane_row(input logic [VW-1:0] v, input int r);
    logic [COLS-1:0] row;
    row = '0;
    for (int i = 0; i < COLS; i++) row[i] = v[i*ROWS + ROWS - 1 - r];
    return row;
  endfunction

  // Present one row and hold it until accepted; returns 1 ns after the
  // accepting edge.
  task automatic send_row(input logic [COLS-1:0] d, input logic last);
    int n;
    n = 0;
    bus.row_in    = d;
    bus.row_valid = 1'b1;
    bus.row_last  = last;
    while (!bus.row_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL row_accept_timeout: row_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [VW-1:0] v, input logic last_flag);
    for (int r = 0; r < ROWS; r++) send_row(plane_row(v, r), (r == ROWS-1) ? last_flag : 1'b0);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.row_in    = 16'hFFFF;
    bus.row_valid = 1'b1;
    bus.row_last  = 1'b1;
    bus.vec_ready = 1'b0;
    err_clr       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL reset_vec_valid: got %b want 0", bus.vec_valid); end
    checks++; if (bus.vec_out !== '0) begin errors++; $display("FAIL reset_vec_out: got %h want 0", bus.vec_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    rst_n         = 1'b1;
    #1;
    checks++; if (bus.row_ready !== 1'b1) begin errors++; $display("FAIL reset_row_ready: got %b want 1", bus.row_ready); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_single_plane();
    bus.vec_ready = 1'b1;
    send_row(16'hFFFF, 1'b0);
    for (int r = 1; r < ROWS-1; r++) begin
      send_row(16'h0000, 1'b0);
      checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL plane_early_valid row %0d: got %b want 0", r, bus.vec_valid); end
    end
    send_row(16'h0000, 1'b1);
    exp_cnt++;
    checks++; if (bus.vec_valid !== 1'b1) begin errors++; $display("FAIL plane_vec_valid: got %b want 1", bus.vec_valid); end
    checks++; if (bus.vec_out !== 128'h8080_8080_8080_8080_8080_8080_8080_8080) begin
      errors++; $display("FAIL plane_vec_out: got %h want 8080...8080", bus.vec_out); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL plane_frame_cnt: got %0d want 1", frame_cnt); end
    @(posedge clk); #1;
    checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL plane_vec_drain: got %b want 0", bus.vec_valid); end
  endtask

  task automatic test_lane_corner();
    for (int r = 0; r < ROWS; r++) send_row((r == ROWS-1) ? 16'h0001 : 16'h0000, r == ROWS-1);
    exp_cnt++;
    checks++; if (bus.vec_out !== 128'h1) begin errors++; $display("FAIL corner_lane0_bit0: got %h want 1", bus.vec_out); end
    for (int r = 0; r < ROWS; r++) send_row((r == 0) ? 16'h8000 : 16'h0000, r == ROWS-1);
    exp_cnt++;
    checks++; if (bus.vec_out !== {8'h80, 120'h0}) begin errors++; $display("FAIL corner_lane15_bit7: got %h want 80 then zeros", bus.vec_out); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL corner_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_round_trip();
    logic [VW-1:0] v;
    for (int f = 0; f < 1000; f++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      send_frame(v, 1'b1);
      exp_cnt++;
      checks++; if (bus.vec_valid !== 1'b1 || bus.vec_out !== v) begin
        errors++; $display("FAIL round_trip frame %0d: valid=%b got %h want %h", f, bus.vec_valid, bus.vec_out, v); end
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL round_trip_frame_err: got %b want 0", frame_err); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL round_trip_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] va, vb;
    va = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    vb = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_1111_EEEE;
    @(posedge clk); #1;
    bus.vec_ready = 1'b0;
    send_frame(va, 1'b1);
    exp_cnt++;
    for (int r = 0; r < ROWS-1; r++) send_row(plane_row(vb, r), 1'b0);
    bus.row_in    = plane_row(vb, ROWS-1);
    bus.row_last  = 1'b1;
    bus.row_valid = 1'b1;
    #1;
    checks++; if (bus.row_ready !== 1'b0) begin errors++; $display("FAIL bp_row_ready_stall: got %b want 0", bus.row_ready); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.row_ready !== 1'b0) begin errors++; $display("FAIL bp_row_ready_hold: got %b want 0", bus.row_ready); end
    checks++; if (bus.vec_valid !== 1'b1 || bus.vec_out !== va) begin
      errors++; $display("FAIL bp_hold_a: valid=%b got %h want %h", bus.vec_valid, bus.vec_out, va); end
    bus.vec_ready = 1'b1;
    #1;
    checks++; if (bus.row_ready !== 1'b1) begin errors++; $display("FAIL bp_row_ready_release: got %b want 1", bus.row_ready); end
    @(posedge clk); #1;
    exp_cnt++;
    bus.row_valid = 1'b0;
    bus.row_last  = 1'b0;
    checks++; if (bus.vec_valid !== 1'b1 || bus.vec_out !== vb) begin
      errors++; $display("FAIL bp_b_follows: valid=%b got %h want %h", bus.vec_valid, bus.vec_out, vb); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL bp_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    @(posedge clk); #1;
    checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.vec_valid); end
  endtask

  task automatic test_framing();
    logic [VW-1:0] vc, ve;
    vc = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    ve = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    for (int r = 0; r < 4; r++) send_row(16'hFFFF, r == 3);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err: got %b want 1", frame_err); end
    @(posedge clk); #1;
    checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL short_no_output: got %b want 0", bus.vec_valid); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL short_frame_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
    send_frame(vc, 1'b1);
    exp_cnt++;
    checks++; if (bus.vec_valid !== 1'b1 || bus.vec_out !== vc) begin
      errors++; $display("FAIL after_short_vec: valid=%b got %h want %h", bus.vec_valid, bus.vec_out, vc); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_sticky: got %b want 1", frame_err); end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b want 0", frame_err); end
    send_frame(ve, 1'b0);
    exp_cnt++;
    checks++; if (bus.vec_valid !== 1'b1 || bus.vec_out !== ve) begin
      errors++; $display("FAIL missing_last_vec: valid=%b got %h want %h", bus.vec_valid, bus.vec_out, ve); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL missing_last_err: got %b want 1", frame_err); end
    checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL missing_last_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_mid_frame_reset();
    logic [VW-1:0] vd;
    vd = 128'h7766_5544_3322_1100_FFEE_DDCC_BBAA_9988;
    for (int r = 0; r < 5; r++) send_row(16'hAAAA, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (frame_err !== 1'b0 || frame_cnt !== 16'd0 || bus.vec_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state: err=%b cnt=%0d valid=%b want 0 0 0", frame_err, frame_cnt, bus.vec_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(vd, 1'b1);
    checks++; if (bus.vec_valid !== 1'b1 || bus.vec_out !== vd) begin
      errors++; $display("FAIL midreset_vec: valid=%b got %h want %h", bus.vec_valid, bus.vec_out, vd); end
    checks++; if (frame_cnt !== 16'd1 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_cnt_err: cnt=%0d err=%b want 1 0", frame_cnt, frame_err); end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 16'd0;
    test_reset();
    test_single_plane();
    test_lane_corner();
    test_round_trip();
    test_back_to_back();
    test_framing();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
